// File: rtl/spi_pkg.sv
// Shared types for the SPI master: FSM state and latched transfer mode.
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    LEAD,
    TRAIL,
    HOLD
  } spi_state_t;

  typedef struct packed {
    logic cpol;
    logic cpha;
    logic lsb_first;
  } spi_mode_t;

endpackage

// File: rtl/spi_clk_div.sv
// Half-period tick generator; counter wraps on tick or on clr.
module spi_clk_div #(
  parameter int CLK_DIV = 50
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic tick
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] r_cnt;

  assign tick = (r_cnt == CW'(CLK_DIV - 1));

  always_ff @(posedge clk) begin
    if (reset || clr || tick) r_cnt <= '0;
    else                      r_cnt <= r_cnt + 1'b1;
  end

endmodule

// File: rtl/spi_master_gen.sv
// SPI master: all four modes, MSB/LSB first, decoded active-low chip selects.
module spi_master_gen
  import spi_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int NUM_CS  = 2,
  parameter int CLK_DIV = 50,
  localparam int CSW = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpol,
  input  logic              cpha,
  input  logic              lsb_first,
  input  logic [CSW-1:0]    cs_sel,
  input  logic              start,
  input  logic [DATA_W-1:0] tx_data,
  output logic [DATA_W-1:0] rx_data,
  output logic              tx_ready,
  output logic              done,
  output logic              SCLK,
  output logic              MOSI,
  input  logic              MISO,
  output logic [NUM_CS-1:0] CS_N
);

  localparam int BW = $clog2(DATA_W + 1);

  spi_state_t        r_state;
  spi_mode_t         r_mode;
  logic [DATA_W-1:0] r_sh;
  logic [BW-1:0]     r_bits;
  logic              r_sclk;
  logic              r_mosi;
  logic [NUM_CS-1:0] r_cs_n;
  logic [DATA_W-1:0] r_rx;
  logic              r_ready;
  logic              r_done;

  logic              w_tick;
  logic              w_clr;
  logic [NUM_CS-1:0] w_cs_dec;
  logic [DATA_W-1:0] w_sh_next;

  function automatic logic out_bit(input logic lsb,
                                   input logic [DATA_W-1:0] v);
    return lsb ? v[0] : v[DATA_W-1];
  endfunction

  assign w_clr = (r_state == IDLE);

  spi_clk_div #(.CLK_DIV(CLK_DIV)) u_div (
    .clk   (clk),
    .reset (reset),
    .clr   (w_clr),
    .tick  (w_tick)
  );

  // Received bits enter opposite to the outgoing end
  assign w_sh_next = r_mode.lsb_first ?
                     {MISO, r_sh[DATA_W-1:1]} :
                     {r_sh[DATA_W-2:0], MISO};

  always_comb begin
    w_cs_dec = '1;
    for (int i = 0; i < NUM_CS; i++)
      if (cs_sel == CSW'(i)) w_cs_dec[i] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_mode  <= '0;
      r_sh    <= '0;
      r_bits  <= '0;
      r_sclk  <= 1'b0;
      r_mosi  <= 1'b0;
      r_cs_n  <= '1;
      r_rx    <= '0;
      r_ready <= 1'b1;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        IDLE: begin
          r_sclk <= cpol;
          if (start && !r_done) begin
            r_mode.cpol      <= cpol;
            r_mode.cpha      <= cpha;
            r_mode.lsb_first <= lsb_first;
            r_sh    <= tx_data;
            r_bits  <= '0;
            r_cs_n  <= w_cs_dec;
            r_ready <= 1'b0;
            r_mosi  <= cpha ? 1'b0 : out_bit(lsb_first, tx_data);
            r_state <= SETUP;
          end
        end
        SETUP: if (w_tick) begin
          r_state <= LEAD;
          r_sclk  <= ~r_mode.cpol;
          if (r_mode.cpha) r_mosi <= out_bit(r_mode.lsb_first, r_sh);
        end
        LEAD: if (w_tick) begin
          r_state <= TRAIL;
          r_sclk  <= r_mode.cpol;
          if (!r_mode.cpha) r_sh <= w_sh_next;
        end
        TRAIL: if (w_tick) begin
          r_bits <= r_bits + 1'b1;
          if (r_mode.cpha) r_sh <= w_sh_next;
          if (r_bits == BW'(DATA_W - 1)) begin
            r_state <= HOLD;
            r_sclk  <= r_mode.cpol;
          end else begin
            r_state <= LEAD;
            r_sclk  <= ~r_mode.cpol;
            r_mosi  <= out_bit(r_mode.lsb_first,
                               r_mode.cpha ? w_sh_next : r_sh);
          end
        end
        HOLD: if (w_tick) begin
          r_state <= IDLE;
          r_cs_n  <= '1;
          r_rx    <= r_sh;
          r_done  <= 1'b1;
          r_ready <= 1'b1;
          r_sclk  <= cpol;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign rx_data  = r_rx;
  assign tx_ready = r_ready;
  assign done     = r_done;
  assign SCLK     = r_sclk;
  assign MOSI     = r_mosi;
  assign CS_N     = r_cs_n;

endmodule

// File: tb/tb_spi_master_gen.sv
// Bench for spi_master_gen: directed table, random modes, corner sequences.
module tb_spi_master_gen;

  localparam int DW_A  = 8;
  localparam int CD_A  = 2;
  localparam int LAT_A = 1 + CD_A * (2 * DW_A + 2);
  localparam int LAT_B = 1 + 1 * (2 * 16 + 2);
  localparam int LIM   = 200;

  typedef struct {
    logic       cpol;
    logic       cpha;
    logic       lsb;
    logic [1:0] cs;
    logic [7:0] tx;
    logic [7:0] sw;
    logic       lb;
    logic [7:0] exp_rx;
    logic [3:0] exp_cs;
  } vec_t;

  logic clk = 0;
  always #5 clk = ~clk;

  // DUT A: 8-bit, 4 selects, divide by 2
  logic       rst_a, cpol_a, cpha_a, lsb_a, start_a, lb_a;
  logic [1:0] cs_a;
  logic [7:0] tx_a, rx_a, sw_a;
  logic       rdy_a, done_a, sclk_a, mosi_a, miso_a;
  logic [3:0] cs_n_a;

  // DUT B: 16-bit, 5 selects, divide by 1, loopback
  logic        rst_b, cpol_b, cpha_b, lsb_b, start_b;
  logic [2:0]  cs_b;
  logic [15:0] tx_b, rx_b;
  logic        rdy_b, done_b, sclk_b, mosi_b;
  logic [4:0]  cs_n_b;

  int pass_cnt = 0;
  int tot_cnt  = 0;

  // Slave model state for A
  int          e_a = 0;
  int          cap_n = 0;
  logic [31:0] cap_a = '0;
  logic [3:0]  cs_and = '1, cs_or = '0;
  logic [4:0]  cs_and_b = '1, cs_or_b = '0;
  int          done_cnt = 0;
  logic        p_rdy = 1, p_sclk = 0, p_rdy_b = 1;

  // Slave shifts its word out one bit per SCLK period, natural order
  function automatic logic slave_bit(input int e, input logic ph,
                                     input logic lsb,
                                     input logic [7:0] w);
    int k;
    k = ph ? ((e == 0) ? 0 : (e - 1) / 2) : e / 2;
    if (k > 7) k = 7;
    return lsb ? w[k] : w[7-k];
  endfunction

  assign miso_a = lb_a ? mosi_a : slave_bit(e_a, cpha_a, lsb_a, sw_a);

  spi_master_gen #(.DATA_W(8), .NUM_CS(4), .CLK_DIV(CD_A)) u_a (
    .clk(clk), .reset(rst_a), .cpol(cpol_a), .cpha(cpha_a),
    .lsb_first(lsb_a), .cs_sel(cs_a), .start(start_a),
    .tx_data(tx_a), .rx_data(rx_a), .tx_ready(rdy_a),
    .done(done_a), .SCLK(sclk_a), .MOSI(mosi_a), .MISO(miso_a),
    .CS_N(cs_n_a)
  );

  spi_master_gen #(.DATA_W(16), .NUM_CS(5), .CLK_DIV(1)) u_b (
    .clk(clk), .reset(rst_b), .cpol(cpol_b), .cpha(cpha_b),
    .lsb_first(lsb_b), .cs_sel(cs_b), .start(start_b),
    .tx_data(tx_b), .rx_data(rx_b), .tx_ready(rdy_b),
    .done(done_b), .SCLK(sclk_b), .MOSI(mosi_b), .MISO(mosi_b),
    .CS_N(cs_n_b)
  );

  always @(negedge clk) begin
    if (rst_a) begin
      e_a   <= 0;
      cap_n <= 0;
    end else begin
      if (p_rdy && !rdy_a) begin
        e_a    <= 0;
        cap_n  <= 0;
        cap_a  <= '0;
        cs_and <= cs_n_a;
        cs_or  <= cs_n_a;
      end else if (!rdy_a) begin
        cs_and <= cs_and & cs_n_a;
        cs_or  <= cs_or | cs_n_a;
        if (sclk_a !== p_sclk) begin
          e_a <= e_a + 1;
          if (e_a % 2 == 1 && cap_n < 32) begin
            cap_a[cap_n] <= mosi_a;
            cap_n <= cap_n + 1;
          end
        end
      end
      if (done_a) done_cnt <= done_cnt + 1;
    end
    p_rdy  <= rdy_a;
    p_sclk <= sclk_a;
    if (p_rdy_b && !rdy_b) begin
      cs_and_b <= cs_n_b;
      cs_or_b  <= cs_n_b;
    end else if (!rdy_b) begin
      cs_and_b <= cs_and_b & cs_n_b;
      cs_or_b  <= cs_or_b | cs_n_b;
    end
    p_rdy_b <= rdy_b;
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tot_cnt++;
    if (act !== exp)
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else
      pass_cnt++;
  endtask

  // MOSI bits captured at each trailing edge, reassembled in word order
  function automatic logic [7:0] mosi_word(input logic lsb);
    logic [7:0] w;
    w = '0;
    for (int i = 0; i < 8; i++) w[lsb ? i : 7 - i] = cap_a[i];
    return w;
  endfunction

  task automatic wait_done_a(inout int n);
    while (n < LIM) begin
      @(negedge clk);
      start_a = 0;
      n++;
      if (done_a) break;
    end
  endtask

  task automatic xfer(input vec_t v);
    int n;
    @(negedge clk);
    cpol_a = v.cpol; cpha_a = v.cpha; lsb_a = v.lsb;
    cs_a = v.cs; tx_a = v.tx; sw_a = v.sw; lb_a = v.lb;
    repeat (3) @(negedge clk);
    chk("sclk_idle", sclk_a, v.cpol);
    start_a = 1;
    n = 0;
    wait_done_a(n);
    chk("latency", n, LAT_A);
    chk("rx", rx_a, v.exp_rx);
    chk("mosi_seq", mosi_word(v.lsb), v.tx);
    chk("sclk_edges", e_a, 16);
    chk("cs_and", cs_and, v.exp_cs);
    chk("cs_or", cs_or, v.exp_cs);
    chk("ready_done", rdy_a, 1);
    @(negedge clk);
    chk("done_pulse", done_a, 0);
    chk("sclk_after", sclk_a, v.cpol);
  endtask

  task automatic xfer_b(input logic pol, input logic ph,
                        input logic lsb, input logic [2:0] cs,
                        input logic [15:0] tx,
                        input logic [4:0] exp_cs);
    int n;
    @(negedge clk);
    cpol_b = pol; cpha_b = ph; lsb_b = lsb; cs_b = cs; tx_b = tx;
    repeat (3) @(negedge clk);
    start_b = 1;
    n = 0;
    while (n < LIM) begin
      @(negedge clk);
      start_b = 0;
      n++;
      if (done_b) break;
    end
    chk("b_latency", n, LAT_B);
    chk("b_rx", rx_b, tx);
    chk("b_cs_and", cs_and_b, exp_cs);
    chk("b_cs_or", cs_or_b, exp_cs);
  endtask

  vec_t tbl[6];

  initial begin
    int n;
    int dc0;
    tbl[0] = '{0, 0, 0, 2'd0, 8'hA5, 8'h00, 1, 8'hA5, 4'hE};
    tbl[1] = '{0, 1, 0, 2'd0, 8'h3C, 8'hC3, 0, 8'hC3, 4'hE};
    tbl[2] = '{1, 0, 0, 2'd1, 8'h3C, 8'hC3, 0, 8'hC3, 4'hD};
    tbl[3] = '{1, 1, 0, 2'd3, 8'h3C, 8'hC3, 0, 8'hC3, 4'h7};
    tbl[4] = '{0, 0, 1, 2'd0, 8'h01, 8'h80, 0, 8'h80, 4'hE};
    tbl[5] = '{0, 0, 0, 2'd2, 8'hA5, 8'h5A, 0, 8'h5A, 4'hB};

    rst_a = 1; cpol_a = 0; cpha_a = 0; lsb_a = 0; start_a = 0;
    cs_a = 0; tx_a = 0; sw_a = 0; lb_a = 0;
    rst_b = 1; cpol_b = 0; cpha_b = 0; lsb_b = 0; start_b = 0;
    cs_b = 0; tx_b = 0;
    repeat (3) @(negedge clk);
    chk("rst_cs_n", cs_n_a, 4'hF);
    chk("rst_ready", rdy_a, 1);
    chk("rst_done", done_a, 0);
    chk("rst_rx", rx_a, 0);
    chk("rst_sclk_mosi", {sclk_a, mosi_a}, 0);
    chk("rst_b_cs_n", cs_n_b, 5'h1F);
    rst_a = 0;
    rst_b = 0;

    foreach (tbl[i]) xfer(tbl[i]);

    for (int i = 0; i < 12; i++) begin
      vec_t r;
      r.cpol   = 1'($urandom_range(0, 1));
      r.cpha   = 1'($urandom_range(0, 1));
      r.lsb    = 1'($urandom_range(0, 1));
      r.cs     = 2'($urandom_range(0, 3));
      r.tx     = 8'($urandom);
      r.sw     = 8'($urandom);
      r.lb     = 0;
      r.exp_rx = r.sw;
      r.exp_cs = ~(4'b0001 << r.cs);
      xfer(r);
    end

    // Start mid-transfer and in the done cycle is dropped; next cycle wins
    @(negedge clk);
    cpol_a = 0; cpha_a = 0; lsb_a = 0; cs_a = 0;
    tx_a = 8'h5A; sw_a = 8'h96; lb_a = 0;
    repeat (2) @(negedge clk);
    start_a = 1;
    n = 0;
    repeat (10) begin
      @(negedge clk);
      start_a = 0;
      n++;
    end
    start_a = 1;
    tx_a = 8'hFF;
    wait_done_a(n);
    chk("ign_latency", n, LAT_A);
    chk("ign_rx", rx_a, 8'h96);
    chk("ign_mosi", mosi_word(0), 8'h5A);
    start_a = 1;
    tx_a = 8'h11;
    sw_a = 8'h22;
    @(negedge clk);
    chk("done_cycle_start", rdy_a, 1);
    @(negedge clk);
    chk("after_done_start", rdy_a, 0);
    start_a = 0;
    n = 1;
    wait_done_a(n);
    chk("second_latency", n, LAT_A);
    chk("second_rx", rx_a, 8'h22);
    chk("second_mosi", mosi_word(0), 8'h11);

    // Reset during bit 4 aborts immediately
    @(negedge clk);
    tx_a = 8'h33; sw_a = 8'h44; cs_a = 1;
    repeat (2) @(negedge clk);
    dc0 = done_cnt;
    start_a = 1;
    repeat (20) begin
      @(negedge clk);
      start_a = 0;
    end
    chk("abort_busy", rdy_a, 0);
    rst_a = 1;
    cpol_a = 1;
    @(negedge clk);
    chk("abort_cs_n", cs_n_a, 4'hF);
    chk("abort_ready", rdy_a, 1);
    chk("abort_done", done_a, 0);
    chk("abort_rx", rx_a, 0);
    chk("abort_sclk_mosi", {sclk_a, mosi_a}, 0);
    rst_a = 0;
    repeat (60) @(negedge clk);
    chk("abort_no_done", done_cnt, dc0);
    chk("post_rst_sclk", sclk_a, 1);

    xfer_b(0, 0, 0, 3'd5, 16'hBEEF, 5'h1F);
    xfer_b(1, 1, 1, 3'd3, 16'h1234, 5'b10111);
    xfer_b(0, 1, 0, 3'd0, 16'hC0DE, 5'b11110);

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
